pre_unmix_stream: RTL and testbench

//  Word-serial inverse of the 640-bit pre-mix stage used on the miner datapath.

---
 rtl/pre_mix_pkg.sv | 13 +
 rtl/pre_unmix_buf.sv | 31 +++
 rtl/pre_unmix_stream.sv | 145 ++++++++++++++
 tb/tb_pre_unmix_stream.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pre_mix_pkg.sv
// rtl/pre_mix_pkg.sv - shared constants and state type for the pre-mix / pre-unmix stages
package pre_mix_pkg;

  localparam int NWORDS = 20;
  localparam int WORD_W = 32;
  localparam int CNT_W  = $clog2(NWORDS);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

endpackage

// File: rtl/pre_unmix_buf.sv
// rtl/pre_unmix_buf.sv - NWORDS x WORD_W block buffer, one write port, one async read port (PRE_UNMIX_BLOCK_OUT_EN adds a flat view)
module pre_unmix_buf
  import pre_mix_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [CNT_W-1:0]  i_widx,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [CNT_W-1:0]  i_ridx,
`ifdef PRE_UNMIX_BLOCK_OUT_EN
  output logic [NWORDS*WORD_W-1:0] o_flat,
`endif
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [NWORDS];

  // Storage is never read before being written for the current block, so no reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_ridx];

`ifdef PRE_UNMIX_BLOCK_OUT_EN
  for (genvar g = 0; g < NWORDS; g++) begin : g_flat
    assign o_flat[g*WORD_W +: WORD_W] = r_mem[g];
  end
`endif

endmodule

// File: rtl/pre_unmix_stream.sv
// rtl/pre_unmix_stream.sv - word-serial inverse of the pre-mix stage (optional PRE_UNMIX_BLOCK_OUT_EN full-block port)
module pre_unmix_stream
  import pre_mix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
`ifdef PRE_UNMIX_BLOCK_OUT_EN
  output logic [NWORDS*WORD_W-1:0] out_block,
  output logic                     out_block_valid,
`endif
  output logic              err_len
);

  // XOR of the mixed words only equals XOR of the originals for an even word count.
  if ((NWORDS % 2) != 0) begin : g_odd_nwords
    $error("pre_unmix_stream: NWORDS must be even");
  end

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [WORD_W-1:0]  r_acc, w_acc_nxt;
  logic [WORD_W-1:0]  r_t, w_t_nxt;
  logic               r_err_len, w_err_nxt;
  logic               w_we;
  logic               w_in_fire, w_out_fire, w_at_end;
  logic [WORD_W-1:0]  w_rdata;

  assign w_at_end   = (r_count == CNT_W'(NWORDS - 1));
  assign in_ready   = (r_state == COLLECT);
  assign out_valid  = (r_state == EMIT);
  assign out_last   = out_valid & w_at_end;
  assign out_data   = out_valid ? (w_rdata ^ r_t) : '0;
  assign err_len    = r_err_len;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

`ifdef PRE_UNMIX_BLOCK_OUT_EN
  logic [NWORDS*WORD_W-1:0] w_flat, w_block;
  logic                     w_block_load;
`endif

  pre_unmix_buf u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_widx  (r_count),
    .i_wdata (in_data),
    .i_ridx  (r_count),
`ifdef PRE_UNMIX_BLOCK_OUT_EN
    .o_flat  (w_flat),
`endif
    .o_rdata (w_rdata)
  );

  // Next-state: collect/accumulate words, then replay them XORed with T.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_acc_nxt   = r_acc;
    w_t_nxt     = r_t;
    w_err_nxt   = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_in_fire) begin
          w_we = 1'b1;
          if (w_at_end) begin
            w_t_nxt     = r_acc ^ in_data;
            w_acc_nxt   = '0;
            w_count_nxt = '0;
            w_err_nxt   = ~in_last;
            w_state_nxt = EMIT;
          end else if (in_last) begin
            w_acc_nxt   = '0;
            w_count_nxt = '0;
            w_err_nxt   = 1'b1;
          end else begin
            w_acc_nxt   = r_acc ^ in_data;
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
      end
      EMIT: begin
        if (w_out_fire) begin
          if (w_at_end) begin
            w_count_nxt = '0;
            w_acc_nxt   = '0;
            w_state_nxt = COLLECT;
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // State, counter, accumulator, T and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= COLLECT;
      r_count   <= '0;
      r_acc     <= '0;
      r_t       <= '0;
      r_err_len <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_acc     <= w_acc_nxt;
      r_t       <= w_t_nxt;
      r_err_len <= w_err_nxt;
    end
  end

`ifdef PRE_UNMIX_BLOCK_OUT_EN
  // The final word is still on in_data when the block completes, so it bypasses the buffer.
  assign w_block_load = w_in_fire & w_at_end;
  for (genvar g = 0; g < NWORDS; g++) begin : g_block
    if (g == NWORDS - 1) begin : g_last
      assign w_block[g*WORD_W +: WORD_W] = in_data ^ w_t_nxt;
    end else begin : g_mid
      assign w_block[g*WORD_W +: WORD_W] = w_flat[g*WORD_W +: WORD_W] ^ w_t_nxt;
    end
  end

  // Full recovered block, captured on COLLECT->EMIT and held until the next block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_block       <= '0;
      out_block_valid <= 1'b0;
    end else begin
      out_block_valid <= w_block_load;
      if (w_block_load) out_block <= w_block;
    end
  end
`endif

endmodule

// File: tb/tb_pre_unmix_stream.sv
// tb/tb_pre_unmix_stream.sv - self-checking bench for pre_unmix_stream
module tb_pre_unmix_stream;
  import pre_mix_pkg::*;

  localparam int NW = NWORDS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        err_len;
`ifdef PRE_UNMIX_BLOCK_OUT_EN
  logic [NW*32-1:0] out_block;
  logic             out_block_valid;
  logic [NW*32-1:0] cap_block;
  int               bv_pulses = 0;
`endif

  always #5 clk = ~clk;

  pre_unmix_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef PRE_UNMIX_BLOCK_OUT_EN
    .out_block       (out_block),
    .out_block_valid (out_block_valid),
`endif
    .err_len   (err_len)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output-side observers
  logic [31:0] got_data[$];
  bit          got_last[$];
  int          err_pulses = 0;
  int          stall_viol = 0;
  int          ready_viol = 0;
  bit          stalled = 1'b0;
  logic [31:0] stall_data;
  bit          rnd_rdy = 1'b0;

  always @(posedge clk) begin
    #1;
    out_ready = rnd_rdy ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled && (!out_valid || out_data !== stall_data)) stall_viol++;
      if (out_valid && in_ready) ready_viol++;
      if (err_len) err_pulses++;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled    = 1'b1;
        stall_data = out_data;
      end else begin
        stalled = 1'b0;
      end
`ifdef PRE_UNMIX_BLOCK_OUT_EN
      if (out_block_valid) begin
        bv_pulses++;
        cap_block = out_block;
      end
`endif
    end
  end

  // Reference model: T is the XOR of the whole block, each output is its word XOR T.
  logic [31:0] blk [NW];

  function automatic logic [31:0] model_word(input int i);
    logic [31:0] t = '0;
    for (int j = 0; j < NW; j++) t ^= blk[j];
    return blk[i] ^ t;
  endfunction

  task automatic fill(input int pat, input logic [31:0] val);
    for (int i = 0; i < NW; i++) begin
      case (pat)
        0:       blk[i] = 32'(i + 1) ^ 32'h14;
        1:       blk[i] = val;
        default: blk[i] = $urandom;
      endcase
    end
  endtask

  task automatic send_word(input logic [31:0] d, input bit l, input bit gaps);
    int n = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  // last_pos: index carrying in_last, or -1 for none
  task automatic run_block(input string name, input int last_pos, input bit gaps,
                           input bit exp_err, input bit exp_emit);
    int e0, s0, r0, n, nsend;
    got_data.delete();
    got_last.delete();
    e0 = err_pulses;
    s0 = stall_viol;
    r0 = ready_viol;
    nsend = (last_pos >= 0 && last_pos < NW) ? last_pos + 1 : NW;
    for (int i = 0; i < nsend; i++) send_word(blk[i], (i == last_pos), gaps);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (exp_emit) begin
      n = 0;
      while (got_data.size() < NW && n < 3000) begin
        @(negedge clk);
        n++;
      end
    end else begin
      repeat (2 * NW) @(negedge clk);
    end
    check({name, "/words"}, got_data.size(), exp_emit ? NW : 0);
    if (exp_emit && got_data.size() == NW) begin
      for (int i = 0; i < NW; i++) begin
        check($sformatf("%s/data%0d", name, i), got_data[i], model_word(i));
        check($sformatf("%s/last%0d", name, i), got_last[i], (i == NW - 1));
      end
    end
    check({name, "/err_len"}, err_pulses - e0, exp_err);
    check({name, "/stable"}, stall_viol - s0, 0);
    check({name, "/in_ready_emit"}, ready_viol - r0, 0);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "/in_ready"},  in_ready,  1);
    check({name, "/out_valid"}, out_valid, 0);
    check({name, "/out_last"},  out_last,  0);
    check({name, "/out_data"},  out_data,  0);
    check({name, "/err_len"},   err_len,   0);
  endtask

  typedef struct {
    string       name;
    int          pat;
    logic [31:0] val;
    int          last_pos;
    bit          gaps;
    bit          rnd_rdy;
    bit          exp_err;
    bit          exp_emit;
  } vec_t;

  vec_t tbl[7];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lp;
    bit ee, em;

    tbl[0] = '{"ramp",      0, 32'h0,        NW - 1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{"zeros",     1, 32'h0,        NW - 1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{"ones",      1, 32'hFFFFFFFF, NW - 1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{"short5",    0, 32'h0,        5,      1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{"after_short", 0, 32'h0,      NW - 1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{"no_last",   0, 32'h0,        -1,     1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{"stall30",   2, 32'h0,        NW - 1, 1'b1, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      fill(tbl[k].pat, tbl[k].val);
      rnd_rdy = tbl[k].rnd_rdy;
`ifdef PRE_UNMIX_BLOCK_OUT_EN
      bv_pulses = 0;
`endif
      run_block(tbl[k].name, tbl[k].last_pos, tbl[k].gaps, tbl[k].exp_err, tbl[k].exp_emit);
      if (k == 0 && got_data.size() == NW) begin
        check("ramp/first_is_1",   got_data[0],      1);
        check("ramp/last_is_20",   got_data[NW - 1], NW);
`ifdef PRE_UNMIX_BLOCK_OUT_EN
        check("ramp/block_pulses", bv_pulses, 1);
        for (int i = 0; i < NW; i++)
          check($sformatf("ramp/block%0d", i), cap_block[i*32 +: 32], i + 1);
`endif
      end
      if (k == 2 && got_data.size() == NW) check("ones/word7", got_data[7], 32'hFFFFFFFF);
    end
    rnd_rdy = 1'b0;

    // Reset in the middle of a block, then a fresh block
    fill(0, 32'h0);
    for (int i = 0; i <= 10; i++) send_word(blk[i], 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block("post_reset", NW - 1, 1'b0, 1'b0, 1'b1);
    if (got_data.size() == NW) check("post_reset/word10", got_data[10], 11);

    // Randomized blocks with random framing, input gaps and output back-pressure
    for (int k = 0; k < 8; k++) begin
      fill(2, 32'h0);
      case ($urandom_range(0, 3))
        0:       lp = -1;
        1:       lp = $urandom_range(0, NW - 2);
        default: lp = NW - 1;
      endcase
      em = (lp == -1 || lp == NW - 1);
      ee = (lp != NW - 1);
      rnd_rdy = $urandom_range(0, 1);
      run_block($sformatf("rand%0d", k), lp, 1'b1, ee, em);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
